pipeline_memp_router: RTL

Parametrised memory-prepare stage for the 8-stage pipeline, sitting between EX and MEMD. It registers the EX-stage memory request, decodes the target among `NUM_CH` address-mapped channels, aligns store data and byte strobes, and detects misaligned accesses. Each channel gets a valid/ready handshake, and the stage raises a hold request that stalls upstream until the selected channel accepts.

---
 rtl/memp_pkg.sv | 65 ++++++
 rtl/memp_store_align.sv | 56 +++++
 rtl/pipeline_memp_router.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/memp_pkg.sv
// Shared encodings, state type and helpers for the memory-prepare stage.
package memp_pkg;

    localparam int unsigned CTRL_W = 3;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;

    localparam logic [63:0] DRAM_BASE_ADDR = 64'h8000_0000;

    localparam logic [CTRL_W-1:0] LD_NONE = 3'd0;
    localparam logic [CTRL_W-1:0] LD_LB   = 3'd1;
    localparam logic [CTRL_W-1:0] LD_LBU  = 3'd2;
    localparam logic [CTRL_W-1:0] LD_LH   = 3'd3;
    localparam logic [CTRL_W-1:0] LD_LHU  = 3'd4;
    localparam logic [CTRL_W-1:0] LD_LW   = 3'd5;
    localparam logic [CTRL_W-1:0] LD_LWU  = 3'd6;
    localparam logic [CTRL_W-1:0] LD_LD   = 3'd7;

    localparam logic [CTRL_W-1:0] ST_NONE = 3'd0;
    localparam logic [CTRL_W-1:0] ST_SB   = 3'd1;
    localparam logic [CTRL_W-1:0] ST_SH   = 3'd2;
    localparam logic [CTRL_W-1:0] ST_SW   = 3'd3;
    localparam logic [CTRL_W-1:0] ST_SD   = 3'd4;

    typedef enum logic {
        MEMP_IDLE  = 1'b0,
        MEMP_ISSUE = 1'b1
    } memp_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    function automatic mem_size_t ld_size(input logic [CTRL_W-1:0] ctrl);
        case (ctrl)
            LD_LB, LD_LBU: return SZ_B;
            LD_LH, LD_LHU: return SZ_H;
            LD_LW, LD_LWU: return SZ_W;
            default:       return SZ_D;
        endcase
    endfunction

    function automatic mem_size_t st_size(input logic [CTRL_W-1:0] ctrl);
        case (ctrl)
            ST_SB:   return SZ_B;
            ST_SH:   return SZ_H;
            ST_SW:   return SZ_W;
            default: return SZ_D;
        endcase
    endfunction

    // Natural alignment: an access of 2^n bytes needs the low n address bits clear.
    function automatic logic size_misaligned(input mem_size_t sz, input logic [2:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return (off[1:0] != 2'b00);
            default: return (off != 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/memp_store_align.sv
// Combinational store lane alignment: byte strobes, shifted write data, misalignment flag.
module memp_store_align
    import memp_pkg::*;
(
    input  logic [2:0]        off_i,
    input  logic [CTRL_W-1:0] rd_ctrl_i,
    input  logic [CTRL_W-1:0] wr_ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [STRB_W-1:0] wstrb_c_o,
    output logic [DATA_W-1:0] wdata_c_o,
    output logic              misalign_c_o
);

    logic              ld_mis;
    logic              st_mis;
    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] data_base;

    always_comb begin
        ld_mis       = (rd_ctrl_i != LD_NONE) && size_misaligned(ld_size(rd_ctrl_i), off_i);
        st_mis       = (wr_ctrl_i != ST_NONE) && size_misaligned(st_size(wr_ctrl_i), off_i);
        misalign_c_o = ld_mis | st_mis;
    end

    // Mask store data to the access size, then move it onto the addressed byte lanes.
    always_comb begin
        strb_base = '0;
        data_base = '0;
        case (st_size(wr_ctrl_i))
            SZ_B: begin
                strb_base = 8'h01;
                data_base = DATA_W'(data_i[7:0]);
            end
            SZ_H: begin
                strb_base = 8'h03;
                data_base = DATA_W'(data_i[15:0]);
            end
            SZ_W: begin
                strb_base = 8'h0F;
                data_base = DATA_W'(data_i[31:0]);
            end
            default: begin
                strb_base = 8'hFF;
                data_base = data_i;
            end
        endcase

        wstrb_c_o = '0;
        wdata_c_o = '0;
        if ((wr_ctrl_i != ST_NONE) && !misalign_c_o) begin
            wstrb_c_o = STRB_W'(strb_base << off_i);
            wdata_c_o = DATA_W'(data_base << {off_i, 3'b000});
        end
    end

endmodule

// File: rtl/pipeline_memp_router.sv
// Memory-prepare pipeline stage: registers the EX request, routes it to an
// address-mapped channel over valid/ready and stalls upstream until accepted.
module pipeline_memp_router
    import memp_pkg::*;
#(
    parameter int unsigned              NUM_CH  = 2,
    parameter int unsigned              ADDR_W  = 64,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = {ADDR_W'(DRAM_BASE_ADDR), ADDR_W'(0)},
    localparam int unsigned             CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_EXC,
    input  logic [63:0]       pc_EXC,
    input  logic              rf_wr_en_EXC,
    input  logic [1:0]        rf_wr_sel_EXC,
    input  logic [4:0]        rd_EXC,
    input  logic [ADDR_W-1:0] alu_result_EXC,
    input  logic [CTRL_W-1:0] dm_rd_ctrl_EXC,
    input  logic [CTRL_W-1:0] dm_wr_ctrl_EXC,
    input  logic [DATA_W-1:0] reg_data2_EXC,
    output logic [NUM_CH-1:0] req_valid,
    input  logic [NUM_CH-1:0] req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [STRB_W-1:0] req_wstrb,
    output logic [CTRL_W-1:0] req_rd_ctrl,
    output logic [CTRL_W-1:0] req_wr_ctrl,
    output logic              hold_req,
    output logic              valid_MEMP,
    output logic [63:0]       pc_MEMP,
    output logic              rf_wr_en_MEMP,
    output logic [1:0]        rf_wr_sel_MEMP,
    output logic [4:0]        rd_MEMP,
    output logic [ADDR_W-1:0] alu_result_MEMP,
    output logic [CH_W-1:0]   ch_sel_MEMP,
    output logic              misalign_MEMP
);

    memp_state_t       state_q, state_d;
    logic              valid_q, valid_d;
    logic [63:0]       pc_q, pc_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic [1:0]        rf_wr_sel_q, rf_wr_sel_d;
    logic [4:0]        rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CTRL_W-1:0] rd_ctrl_q, rd_ctrl_d;
    logic [CTRL_W-1:0] wr_ctrl_q, wr_ctrl_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic              misalign_q, misalign_d;

    logic              capture_c;
    logic              accept_c;
    logic              mem_op_c;
    logic              go_issue_c;
    logic              al_mis_c;
    logic [STRB_W-1:0] al_wstrb_c;
    logic [DATA_W-1:0] al_wdata_c;
    logic [CH_W-1:0]   ch_dec_c;

    memp_store_align u_align (
        .off_i        (alu_result_EXC[2:0]),
        .rd_ctrl_i    (dm_rd_ctrl_EXC),
        .wr_ctrl_i    (dm_wr_ctrl_EXC),
        .data_i       (reg_data2_EXC),
        .wstrb_c_o    (al_wstrb_c),
        .wdata_c_o    (al_wdata_c),
        .misalign_c_o (al_mis_c)
    );

    // Bases ascend, so the last matching channel is the highest one.
    always_comb begin
        ch_dec_c = '0;
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            if (alu_result_EXC >= CH_BASE[i*ADDR_W +: ADDR_W]) begin
                ch_dec_c = CH_W'(i);
            end
        end
    end

    always_comb begin
        req_valid = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            req_valid[i] = (state_q == MEMP_ISSUE) && (ch_sel_q == CH_W'(i));
        end
    end

    // Hold drops on the acceptance cycle so the next instruction can be taken back-to-back.
    assign accept_c   = |(req_valid & req_ready);
    assign hold_req   = (state_q == MEMP_ISSUE) & ~accept_c;
    assign capture_c  = ~stall & ~hold_req;
    assign mem_op_c   = valid_EXC & ~flush & ((dm_rd_ctrl_EXC != LD_NONE) | (dm_wr_ctrl_EXC != ST_NONE));
    assign go_issue_c = capture_c & mem_op_c & ~al_mis_c;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEMP_IDLE: begin
                if (go_issue_c) state_d = MEMP_ISSUE;
            end
            MEMP_ISSUE: begin
                if (accept_c) state_d = go_issue_c ? MEMP_ISSUE : MEMP_IDLE;
            end
            default: state_d = MEMP_IDLE;
        endcase
    end

    // Stage fields only move on capture, which keeps the payload stable during ISSUE.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rf_wr_en_d  = rf_wr_en_q;
        rf_wr_sel_d = rf_wr_sel_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        rd_ctrl_d   = rd_ctrl_q;
        wr_ctrl_d   = wr_ctrl_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        ch_sel_d    = ch_sel_q;
        misalign_d  = misalign_q;
        if (capture_c) begin
            valid_d     = valid_EXC & ~flush;
            pc_d        = pc_EXC;
            rf_wr_en_d  = rf_wr_en_EXC & ~(mem_op_c & al_mis_c);
            rf_wr_sel_d = rf_wr_sel_EXC;
            rd_d        = rd_EXC;
            addr_d      = alu_result_EXC;
            rd_ctrl_d   = dm_rd_ctrl_EXC;
            wr_ctrl_d   = dm_wr_ctrl_EXC;
            wdata_d     = mem_op_c ? al_wdata_c : '0;
            wstrb_d     = mem_op_c ? al_wstrb_c : '0;
            ch_sel_d    = ch_dec_c;
            misalign_d  = mem_op_c & al_mis_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MEMP_IDLE;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rf_wr_en_q  <= 1'b0;
            rf_wr_sel_q <= '0;
            rd_q        <= '0;
            addr_q      <= '0;
            rd_ctrl_q   <= '0;
            wr_ctrl_q   <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            ch_sel_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rf_wr_en_q  <= rf_wr_en_d;
            rf_wr_sel_q <= rf_wr_sel_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            rd_ctrl_q   <= rd_ctrl_d;
            wr_ctrl_q   <= wr_ctrl_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            ch_sel_q    <= ch_sel_d;
            misalign_q  <= misalign_d;
        end
    end

    assign req_addr        = addr_q;
    assign req_wdata       = wdata_q;
    assign req_wstrb       = wstrb_q;
    assign req_rd_ctrl     = rd_ctrl_q;
    assign req_wr_ctrl     = wr_ctrl_q;
    assign valid_MEMP      = valid_q;
    assign pc_MEMP         = pc_q;
    assign rf_wr_en_MEMP   = rf_wr_en_q;
    assign rf_wr_sel_MEMP  = rf_wr_sel_q;
    assign rd_MEMP         = rd_q;
    assign alu_result_MEMP = addr_q;
    assign ch_sel_MEMP     = ch_sel_q;
    assign misalign_MEMP   = misalign_q;

endmodule
